controle_escrita_pc: RTL

CONTROLE_ESCRITA_PC -- requirements
Module: controle_escrita_pc

---
 rtl/controle_pc_pkg.sv | 36 +++
 rtl/contador_saturado.sv | 33 +++
 rtl/controle_escrita_pc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/controle_pc_pkg.sv
// Shared types for the PC write controller: FSM states, request types,
// pc_src encodings and the branch condition evaluation.
package controle_pc_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    ESPERA_ULA = 2'b01,
    ESCREVE    = 2'b10,
    EXCECAO    = 2'b11
  } estado_t;

  typedef enum logic [1:0] {
    TIPO_JUMP = 2'b00,
    TIPO_BEQ  = 2'b01,
    TIPO_BNE  = 2'b10,
    TIPO_BLEZ = 2'b11
  } tipo_t;

  localparam logic [1:0] PC_SRC_MAIS4   = 2'b00;
  localparam logic [1:0] PC_SRC_DESVIO  = 2'b01;
  localparam logic [1:0] PC_SRC_SALTO   = 2'b10;
  localparam logic [1:0] PC_SRC_EXCECAO = 2'b11;

  // A JUMP never reaches the ALU wait, so it evaluates as not taken here.
  function automatic logic condicao_tomada(input tipo_t tipo, input logic zero, input logic neg);
    logic tomada;
    case (tipo)
      TIPO_BEQ:  tomada = zero;
      TIPO_BNE:  tomada = ~zero;
      TIPO_BLEZ: tomada = zero | neg;
      default:   tomada = 1'b0;
    endcase
    return tomada;
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module contador_saturado #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/controle_escrita_pc.sv
// PC write controller: accepts jump/branch requests, waits for ALU flags,
// and issues registered PC write pulses, exception redirects and timeouts.
module controle_escrita_pc
  import controle_pc_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CONT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [1:0]        req_tipo,
  output logic              req_ready,
  input  logic              alu_valid,
  input  logic              alu_zero,
  input  logic              alu_neg,
  input  logic              excecao,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              erro_timeout,
  output logic [CONT_W-1:0] cont_tomados
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  estado_t       estado_q, estado_d;
  tipo_t         tipo_q, tipo_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_ready_q, req_ready_d;
  logic          pc_write_q, pc_write_d;
  logic [1:0]    pc_src_q, pc_src_d;
  logic          erro_q, erro_d;
  logic          handshake_s;
  logic          timeout_s;
  logic          inc_s;

  // State, latched request, wait timer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      tipo_q      <= TIPO_JUMP;
      timer_q     <= {TW{1'b0}};
      req_ready_q <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_src_q    <= PC_SRC_MAIS4;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      tipo_q      <= tipo_d;
      timer_q     <= timer_d;
      req_ready_q <= req_ready_d;
      pc_write_q  <= pc_write_d;
      pc_src_q    <= pc_src_d;
      erro_q      <= erro_d;
    end
  end

  // Next-state logic; an exception preempts everything, including a handshake.
  always_comb begin
    estado_d    = estado_q;
    tipo_d      = tipo_q;
    timer_d     = timer_q;
    timeout_s   = 1'b0;
    handshake_s = req_valid && req_ready_q && (estado_q == OCIOSO) && !excecao;
    if (excecao) begin
      estado_d = EXCECAO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (handshake_s) begin
            tipo_d   = tipo_t'(req_tipo);
            timer_d  = {TW{1'b0}};
            estado_d = (tipo_t'(req_tipo) == TIPO_JUMP) ? ESCREVE : ESPERA_ULA;
          end else begin
            estado_d = OCIOSO;
          end
        end
        ESPERA_ULA: begin
          // Flags arriving in the timeout cycle still win over the error.
          if (alu_valid) begin
            estado_d = condicao_tomada(tipo_q, alu_zero, alu_neg) ? ESCREVE : OCIOSO;
          end else if (timer_q == TIMER_MAX) begin
            timeout_s = 1'b1;
            estado_d  = OCIOSO;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ESCREVE: estado_d = OCIOSO;
        EXCECAO: estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  // Output decode from the next state so outputs line up with the state they describe.
  always_comb begin
    req_ready_d = (estado_d == OCIOSO);
    erro_d      = timeout_s;
    inc_s       = (estado_d == ESCREVE);
    case (estado_d)
      ESCREVE: begin
        pc_write_d = 1'b1;
        pc_src_d   = (tipo_d == TIPO_JUMP) ? PC_SRC_SALTO : PC_SRC_DESVIO;
      end
      EXCECAO: begin
        pc_write_d = 1'b1;
        pc_src_d   = PC_SRC_EXCECAO;
      end
      default: begin
        pc_write_d = 1'b0;
        pc_src_d   = PC_SRC_MAIS4;
      end
    endcase
  end

  contador_saturado #(
    .WIDTH(CONT_W)
  ) u_contador (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (inc_s),
    .count (cont_tomados)
  );

  assign req_ready    = req_ready_q;
  assign pc_write     = pc_write_q;
  assign pc_src       = pc_src_q;
  assign erro_timeout = erro_q;

endmodule
